// File: rtl/imem_boot_pkg.sv
// Shared state type, default widths and settle bounds for the instruction-memory boot loader.
package imem_boot_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADRS_W     = 11;
    localparam int DEF_SETTLE_CYC = 2;
    localparam int SETTLE_CYC_MIN = 1;
    localparam int SETTLE_CYC_MAX = 15;
    localparam int SETTLE_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } boot_state_e;

    // True when a load of count words starting at base stays inside a 2^adrs_w deep memory.
    function automatic logic load_fits(input int base, input int count, input int adrs_w);
        return (base + count) <= (1 << adrs_w);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Word stream handshake plus instruction-memory write port; master is the loader side.
interface imem_boot_loader_if
    import imem_boot_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADRS_W = DEF_ADRS_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] w_instruction;
    logic              w_enable;
    logic [ADRS_W-1:0] w_adrs;

    modport master (
        input  in_data, in_valid,
        output in_ready, w_instruction, w_enable, w_adrs
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, w_instruction, w_enable, w_adrs
    );

endinterface

// File: rtl/loader_checksum.sv
// Running modulo-2^DATA_W sum of accepted words with a compare against an expected value.
// Only present when IMEM_BOOT_LOADER_CHECKSUM_EN is defined.
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
module loader_checksum
    import imem_boot_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] expected_sum,
    output logic              match
);

    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + data;
        end
    end

    assign match = (sum == expected_sum);

endmodule
`endif

// File: rtl/imem_boot_loader.sv
// Streams instruction words into the CPU's instruction memory, then settles and releases cpu_en.
// Optional checksum gate: define IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADRS_W     = DEF_ADRS_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic [ADRS_W-1:0] base_adrs,
    input  logic [ADRS_W:0]   word_count,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0] expected_sum,
`endif
    imem_boot_loader_if.master bus,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYC);
    localparam logic [ADRS_W:0]         REM_ONE     = (ADRS_W+1)'(1);

    boot_state_e             state_q, state_d;
    logic [ADRS_W-1:0]       addr_q, addr_d;
    logic [ADRS_W:0]         remaining_q, remaining_d;
    logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
    logic                    w_enable_d;
    logic [DATA_W-1:0]       w_instruction_d;
    logic [ADRS_W-1:0]       w_adrs_d;
    logic                    error_d;
    logic                    accept;
    logic                    fits;
    logic                    start_ok;

    assign accept   = bus.in_valid & bus.in_ready;
    assign fits     = load_fits(int'(base_adrs), int'(word_count), ADRS_W);
    assign start_ok = start & ((word_count == '0) | fits);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic sum_match;

    loader_checksum #(.DATA_W(DATA_W)) u_checksum (
        .clk          (clk),
        .resetn       (resetn),
        .clear        ((state_q == IDLE) & start_ok),
        .accept       (accept),
        .data         (bus.in_data),
        .expected_sum (expected_sum),
        .match        (sum_match)
    );
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            remaining_q       <= '0;
            settle_q          <= '0;
            bus.in_ready      <= 1'b0;
            bus.w_enable      <= 1'b0;
            bus.w_instruction <= '0;
            bus.w_adrs        <= '0;
            cpu_en            <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            remaining_q       <= remaining_d;
            settle_q          <= settle_d;
            bus.in_ready      <= (state_d == LOAD);
            bus.w_enable      <= w_enable_d;
            bus.w_instruction <= w_instruction_d;
            bus.w_adrs        <= w_adrs_d;
            cpu_en            <= (state_d == RUN);
            busy              <= (state_d == LOAD) || (state_d == SETTLE);
            done              <= (state_d == RUN);
            error             <= error_d;
        end
    end

    // The settle counter restarts on every SETTLE entry; RUN is reached SETTLE_CYC+1 edges later.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        settle_d        = settle_q;
        w_enable_d      = 1'b0;
        w_instruction_d = bus.w_instruction;
        w_adrs_d        = bus.w_adrs;
        error_d         = error;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        error_d  = 1'b0;
                        settle_d = '0;
                        state_d  = SETTLE;
                    end else if (!fits) begin
                        error_d = 1'b1;
                    end else begin
                        addr_d      = base_adrs;
                        remaining_d = word_count;
                        error_d     = 1'b0;
                        state_d     = LOAD;
                    end
                end
            end

            LOAD: begin
                if (accept) begin
                    w_enable_d      = 1'b1;
                    w_instruction_d = bus.in_data;
                    w_adrs_d        = addr_q;
                    addr_d          = addr_q + ADRS_W'(1);
                    remaining_d     = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        settle_d = '0;
                        state_d  = SETTLE;
                    end
                end
            end

            SETTLE: begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                if ((settle_q == '0) && !sum_match) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else
`endif
                if (settle_q == SETTLE_LAST) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + SETTLE_CNT_W'(1);
                end
            end

            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised scoreboard bench for imem_boot_loader: a driver pushes expected writes and
// cpu_en release edges, a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_imem_boot_loader;
    import imem_boot_pkg::*;

    localparam int DATA_W     = 32;
    localparam int ADRS_W     = 11;
    localparam int SETTLE_CYC = 2;
    localparam int DEPTH      = 1 << ADRS_W;

    typedef struct {
        logic [ADRS_W-1:0] adrs;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ADRS_W-1:0] base_adrs = '0;
    logic [ADRS_W:0]   word_count = '0;
    logic              cpu_en, busy, done, error;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] expected_sum = '0;
`endif

    imem_boot_loader_if #(.DATA_W(DATA_W), .ADRS_W(ADRS_W)) bus ();

    imem_boot_loader #(
        .DATA_W     (DATA_W),
        .ADRS_W     (ADRS_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .stop         (stop),
        .base_adrs    (base_adrs),
        .word_count   (word_count),
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        .expected_sum (expected_sum),
`endif
        .bus          (bus),
        .cpu_en       (cpu_en),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    wr_t         exp_wr_q[$];
    int unsigned exp_rise_q[$];
    logic [DATA_W-1:0] words_q[$];
    bit          valid_pat[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops expected writes / release edges whenever the DUT presents them.
    logic              prev_ok = 1'b0;
    logic              prev_cpu_en = 1'b0;
    logic [ADRS_W-1:0] prev_adrs = '0;
    logic [DATA_W-1:0] prev_instr = '0;

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.w_enable) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write actual=adrs 0x%0h required=no write", bus.w_adrs);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    check_output("write_adrs", 64'(bus.w_adrs), 64'(e.adrs));
                    check_output("write_data", 64'(bus.w_instruction), 64'(e.data));
                end
            end else if (prev_ok) begin
                check_output("hold_adrs", 64'(bus.w_adrs), 64'(prev_adrs));
                check_output("hold_data", 64'(bus.w_instruction), 64'(prev_instr));
            end
            if (cpu_en && !prev_cpu_en) begin
                if (exp_rise_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_cpu_en_rise actual=edge %0d required=no rise", cyc);
                end else begin
                    check_output("cpu_en_rise_edge", 64'(cyc), 64'(exp_rise_q.pop_front()));
                end
            end
        end
        prev_ok     <= resetn;
        prev_adrs   <= bus.w_adrs;
        prev_instr  <= bus.w_instruction;
        prev_cpu_en <= cpu_en;
    end

    task automatic fill_random_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // Drives one start plus its word stream; the model says word i lands at base+i, and
    // cpu_en rises SETTLE_CYC+1 edges after the edge that takes the last word (or the start).
    task automatic apply_stimulus(input logic [ADRS_W-1:0] base, input logic [ADRS_W:0] count,
                                  input int gap_pct, input bit bad_sum);
        bit over;
        bit sum_good;
        bit v;
        int sent;
        over = (int'(base) + int'(count)) > DEPTH;
        for (int i = words_q.size(); i < int'(count); i++) words_q.push_back($urandom);
        sum_good = !bad_sum;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        begin
            logic [DATA_W-1:0] sum;
            sum = '0;
            for (int i = 0; i < int'(count); i++) sum = sum + words_q[i];
            expected_sum = bad_sum ? sum + 1 : sum;
        end
`endif
        @(negedge clk);
        start      = 1'b1;
        base_adrs  = base;
        word_count = count;
        if (!over && count == 0 && sum_good) exp_rise_q.push_back(cyc + 1 + SETTLE_CYC + 1);
        @(negedge clk);
        start = 1'b0;
        if (over) begin
            check_output("bound_error", 64'(error), 64'd1);
            check_output("bound_busy", 64'(busy), 64'd0);
            check_output("bound_in_ready", 64'(bus.in_ready), 64'd0);
            words_q.delete();
            return;
        end
        check_output("start_error_clear", 64'(error), 64'd0);
        check_output("start_busy", 64'(busy), 64'd1);
        sent = 0;
        while (sent < int'(count)) begin
            check_output("in_ready_load", 64'(bus.in_ready), 64'd1);
            if (valid_pat.size() != 0) v = valid_pat.pop_front();
            else v = ($urandom_range(0, 99) >= gap_pct);
            bus.in_valid = v;
            bus.in_data  = v ? words_q[sent] : $urandom;
            if (v) begin
                exp_wr_q.push_back('{adrs: base + ADRS_W'(sent), data: words_q[sent]});
                sent++;
                if (sent == int'(count) && sum_good) exp_rise_q.push_back(cyc + 1 + SETTLE_CYC + 1);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (count != 0) check_output("in_ready_after_last", 64'(bus.in_ready), 64'd0);
        words_q.delete();
    endtask

    task automatic wait_not_busy(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output(name, 64'(busy), 64'd0);
    endtask

    task automatic stop_cpu();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_output("stop_cpu_en", 64'(cpu_en), 64'd0);
        check_output("stop_done", 64'(done), 64'd0);
        check_output("stop_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check_output({tag, "_w_enable"}, 64'(bus.w_enable), 64'd0);
        check_output({tag, "_w_adrs"}, 64'(bus.w_adrs), 64'd0);
        check_output({tag, "_w_instr"}, 64'(bus.w_instruction), 64'd0);
        check_output({tag, "_cpu_en"}, 64'(cpu_en), 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_done"}, 64'(done), 64'd0);
        check_output({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 resetn = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        $display("[TB] basic load");
        words_q = '{32'hE000_0007, 32'hC07F_F803, 32'h1234_5678};
        apply_stimulus(11'd4, 12'd3, 0, 1'b0);
        wait_not_busy("basic_settle");
        check_output("basic_done", 64'(done), 64'd1);
        check_output("basic_cpu_en", 64'(cpu_en), 64'd1);
        @(negedge clk);
        start = 1'b1; base_adrs = 11'd0; word_count = 12'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_output("run_ignores_start_done", 64'(done), 64'd1);
        check_output("run_ignores_start_busy", 64'(busy), 64'd0);
        stop_cpu();

        $display("[TB] backpressure gaps");
        valid_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_stimulus(11'd4, 12'd3, 0, 1'b0);
        wait_not_busy("gap_settle");
        check_output("gap_done", 64'(done), 64'd1);
        stop_cpu();

        $display("[TB] bounds");
        apply_stimulus(11'd2040, 12'd9, 0, 1'b0);
        repeat (3) @(negedge clk);
        check_output("bound_stays_idle", 64'(busy), 64'd0);
        apply_stimulus(11'd2040, 12'd8, 20, 1'b0);
        wait_not_busy("bound_ok_settle");
        check_output("bound_ok_done", 64'(done), 64'd1);
        stop_cpu();

        $display("[TB] zero count and stop");
        apply_stimulus(11'd100, 12'd0, 0, 1'b0);
        wait_not_busy("zero_settle");
        check_output("zero_done", 64'(done), 64'd1);
        stop_cpu();
        apply_stimulus(11'd300, 12'd4, 30, 1'b0);
        wait_not_busy("fresh_settle");
        check_output("fresh_done", 64'(done), 64'd1);
        stop_cpu();

        $display("[TB] maximal load");
        fill_random_words(DEPTH);
        apply_stimulus(11'd0, 12'(DEPTH), 0, 1'b0);
        wait_not_busy("max_settle");
        check_output("max_last_adrs", 64'(bus.w_adrs), 64'(DEPTH - 1));
        check_output("max_done", 64'(done), 64'd1);
        stop_cpu();

        $display("[TB] random loads");
        for (int k = 0; k < 12; k++) begin
            logic [ADRS_W-1:0] b;
            logic [ADRS_W:0]   c;
            bit over;
            bit bad;
            b = $urandom_range(0, 1) ? ADRS_W'($urandom_range(0, DEPTH - 1))
                                     : ADRS_W'(DEPTH - int'($urandom_range(1, 12)));
            c = (ADRS_W+1)'($urandom_range(0, 12));
            over = (int'(b) + int'(c)) > DEPTH;
            bad = 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`endif
            apply_stimulus(b, c, 30, bad);
            wait_not_busy("rand_settle");
            if (!over && !bad) begin
                check_output("rand_done", 64'(done), 64'd1);
                stop_cpu();
            end else begin
                check_output("rand_error", 64'(error), 64'd1);
            end
        end

        $display("[TB] reset mid-load");
        fill_random_words(5);
        @(negedge clk);
        start = 1'b1; base_adrs = 11'd500; word_count = 12'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words_q[i];
            exp_wr_q.push_back('{adrs: 11'd500 + ADRS_W'(i), data: words_q[i]});
            @(negedge clk);
        end
        #2 resetn = 1'b0;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check_output("midreset_idle_busy", 64'(busy), 64'd0);
        check_output("midreset_idle_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        words_q.delete();

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        $display("[TB] checksum");
        words_q = '{32'd1, 32'd2, 32'd3};
        apply_stimulus(11'd10, 12'd3, 0, 1'b0);
        wait_not_busy("sum_ok_settle");
        check_output("sum_ok_done", 64'(done), 64'd1);
        stop_cpu();
        words_q = '{32'd1, 32'd2, 32'd3};
        apply_stimulus(11'd10, 12'd3, 0, 1'b1);
        wait_not_busy("sum_bad_settle");
        check_output("sum_bad_error", 64'(error), 64'd1);
        repeat (5) @(negedge clk);
        check_output("sum_bad_cpu_en", 64'(cpu_en), 64'd0);
        check_output("sum_bad_done", 64'(done), 64'd0);
`endif

        repeat (4) @(negedge clk);
        check_output("writes_outstanding", 64'(exp_wr_q.size()), 64'd0);
        check_output("rises_outstanding", 64'(exp_rise_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Parametrised program loader that sits in front of the pipelined CPU's instruction-memory write port (w_instruction / w_enable / w_adrs) and drives cpu_en.
- Accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive addresses from a programmable base.
- Holds the CPU disabled during the load, waits a settle interval, then releases the CPU.
- Replaces hand-sequenced loading with auto-increment, bounds checking and boot sequencing.

Parameters:
- DATA_W, 32, instruction word width.
- ADRS_W, 11, instruction-memory address width (depth 2^ADRS_W).
- SETTLE_CYC, 2, cycles cpu_en stays low after the last write before release (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle load request; sampled only in IDLE.
- stop  in  1  halts the CPU and returns to IDLE; honoured only in RUN.
- base_adrs  in  ADRS_W  first write address, latched on start.
- word_count  in  ADRS_W+1  number of words to load, latched on start.
- in_data  in  DATA_W  instruction word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- w_instruction  out  DATA_W  memory write data.
- w_enable  out  1  memory write strobe.
- w_adrs  out  ADRS_W  memory write address.
- cpu_en  out  1  CPU run enable.
- busy  out  1  high in LOAD or SETTLE.
- done  out  1  high in RUN.
- error  out  1  sticky fault flag.

Behaviour:
- Reset: every output is 0 and the state is IDLE. The reset is asynchronous, so it also aborts a load in progress. Memory contents after a mid-load reset are unspecified.
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE, start=1 and word_count=0: error cleared; go to SETTLE.
- IDLE, start=1 and base_adrs+word_count > 2^ADRS_W: error set to 1; stay in IDLE; no writes.
- IDLE, start=1 otherwise: latch base and count; error cleared; go to LOAD.
- LOAD, handshake:
  - in_ready = 1 throughout LOAD. A word is accepted on any cycle with in_valid & in_ready.
  - Write latency is 1 cycle. The clock edge after an accept drives w_enable=1, w_instruction=the accepted word, and w_adrs=the current address.
  - The address then increments and the remaining count decrements.
  - With no accept, w_enable=0 and w_instruction / w_adrs hold their values.
- LOAD, last word: the edge that accepts the last word moves the state to SETTLE, so in_ready=0 from the next cycle. That final write still appears on that edge.
- SETTLE: counts SETTLE_CYC cycles with cpu_en=0, then moves to RUN. cpu_en rises exactly SETTLE_CYC+1 edges after the accepting edge of the last word.
- RUN: cpu_en=1, done=1. start is ignored. stop=1 gives cpu_en=0 and done=0 on the next edge, and the state returns to IDLE.
- start during LOAD or SETTLE is ignored. stop outside RUN is ignored.
- Address never wraps, because the bounds are checked at start. A maximal load (base 0, count 2^ADRS_W) ends with w_adrs = 2^ADRS_W-1.
- busy = (LOAD or SETTLE). Outputs are registered.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Adds input expected_sum [DATA_W].
  - Keeps a running modulo-2^DATA_W sum of accepted words, cleared on an accepted start.
  - On entry to SETTLE, compares the sum with expected_sum. On mismatch: error=1, return to IDLE, cpu_en is never asserted. On match: behaviour is unchanged.
- Without the macro: the port and the sum logic are absent, and SETTLE always proceeds to RUN.

Decomposition:
- Package imem_boot_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, RUN);
  - default width constants;
  - the SETTLE_CYC bound.
- Sub-module loader_checksum (accumulator plus compare) is instantiated only under the macro. The FSM and counters stay in the top block.

Test Plan:
- Basic load: base=4, count=3, words 0xE000_0007, 0xC07F_F803, 0x1234_5678, in_valid held high. Expected: writes at addresses 4, 5, 6 on the three consecutive edges after each accept; cpu_en=1 exactly 3 edges after the third accept; done=1.
- Backpressure gaps: in_valid toggled 1,0,0,1,0,1 with count=3. Expected: w_enable pulses only after accepts; addresses 4, 5, 6 with no skips; w_adrs holds during gaps.
- Bounds: base=2040, count=9. Expected: error=1, no w_enable, state stays IDLE. A following start with base=2040, count=8 clears error and writes 2040..2047.
- Zero count and stop: count=0. Expected: cpu_en rises SETTLE_CYC+1 edges after start. Then stop=1 gives cpu_en=0 on the next edge, and a fresh start is accepted.
- Reset mid-load: resetn=0 after 2 of 5 accepts. Expected: all outputs 0 immediately, state IDLE; with resetn=1 and no start, no further writes occur.
- Checksum (macro on): words 1, 2, 3 with expected_sum=6. Expected: RUN. The same load with expected_sum=7 gives error=1 and cpu_en stays 0.
